// File: rtl/chasy_rt_pkg.sv
// Shared types, limits and helpers for the chasy real-time clock with alarm.
package chasy_rt_pkg;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned FIELD_W  = 8;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] min;
        logic [7:0] sec;
    } rt_time_t;

    // True when every field of a 24 h binary time is within range.
    function automatic logic rt_time_valid(input rt_time_t t);
        return (t.sec  <= FIELD_W'(SEC_MAX)) &&
               (t.min  <= FIELD_W'(MIN_MAX)) &&
               (t.hour <= FIELD_W'(HOUR_MAX));
    endfunction

    // Map a 24 h hour (0..23) onto the 12 h display range (1..12).
    function automatic logic [7:0] rt_to_12h(input logic [7:0] hour);
        logic [7:0] h12;
        if (hour == 8'd0) begin
            h12 = 8'd12;
        end else if (hour > 8'd12) begin
            h12 = hour - 8'd12;
        end else begin
            h12 = hour;
        end
        return h12;
    endfunction

endpackage

// File: rtl/rt_mod_counter.sv
// Wrap-around counter 0..MAX with synchronous load; carry is asserted when an
// enabled count is about to wrap so the next stage advances on the same edge.
module rt_mod_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MAX   = 59
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_carry_c
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_at_max;

    assign w_at_max  = (r_count == WIDTH'(MAX));
    assign o_carry_c = i_en && w_at_max;
    assign o_count   = r_count;

    // Load has priority over counting.
    always_comb begin
        w_count_nxt = r_count;
        if (i_load) begin
            w_count_nxt = i_load_val;
        end else if (i_en) begin
            w_count_nxt = w_at_max ? '0 : r_count + WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: rtl/chasy_rt_alarm.sv
// Real-time clock: divider, sec/min/hour counters, validated setup and alarm
// loads, single alarm with timed expiry/ack, and 12/24 h display conversion.
module chasy_rt_alarm
    import chasy_rt_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned ALARM_LEN = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run_en,
    input  logic        setup_imp,
    input  logic [23:0] setup_data,
    input  logic        alarm_set_imp,
    input  logic [15:0] alarm_data,
    input  logic        alarm_en,
    input  logic        alarm_ack,
    input  logic        mode_12h,
    output logic [23:0] data_ch,
    output logic        pm,
    output logic        sec_imp,
    output logic        day_imp,
    output logic        alarm_active,
    output logic        setup_err
);

    localparam int unsigned DIV_W  = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
    localparam int unsigned RING_W = $clog2(ALARM_LEN + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_FREQ - 1);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(ALARM_LEN);

    logic [DIV_W-1:0]  r_div;
    logic [7:0]        r_alarm_hour;
    logic [7:0]        r_alarm_min;
    logic              r_alarm_active;
    logic [RING_W-1:0] r_ring_cnt;
    logic              r_sec_imp;
    logic              r_day_imp;
    logic              r_setup_err;

    rt_time_t          w_setup_time;
    rt_time_t          w_time;
    logic              w_tick;
    logic              w_setup_ok;
    logic              w_setup_bad;
    logic              w_alarm_ok;
    logic              w_alarm_bad;
    logic              w_inc;
    logic              w_sec_carry;
    logic              w_min_carry;
    logic              w_hour_carry;
    logic [7:0]        w_min_nxt;
    logic [7:0]        w_hour_nxt;
    logic              w_trigger;
    logic [RING_W-1:0] w_ring_nxt;

    assign w_setup_time = rt_time_t'(setup_data);

    // Load validation; the two strobes are judged independently.
    assign w_setup_ok  = setup_imp && rt_time_valid(w_setup_time);
    assign w_setup_bad = setup_imp && !rt_time_valid(w_setup_time);
    assign w_alarm_ok  = (alarm_data[15:8] <= 8'(HOUR_MAX)) &&
                         (alarm_data[7:0]  <= 8'(MIN_MAX));
    assign w_alarm_bad = alarm_set_imp && !w_alarm_ok;

    // A valid setup on the tick cycle wins: the tick is swallowed.
    assign w_tick = run_en && (r_div == DIV_LAST);
    assign w_inc  = w_tick && !w_setup_ok;

    // Divider freezes on hold and restarts from zero after a valid setup.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else if (w_setup_ok) begin
            r_div <= '0;
        end else if (run_en) begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
        end
    end

    rt_mod_counter #(
        .WIDTH (8),
        .MAX   (SEC_MAX)
    ) u_sec (
        .clock      (clock),
        .reset      (reset),
        .i_en       (w_inc),
        .i_load     (w_setup_ok),
        .i_load_val (w_setup_time.sec),
        .o_count    (w_time.sec),
        .o_carry_c  (w_sec_carry)
    );

    rt_mod_counter #(
        .WIDTH (8),
        .MAX   (MIN_MAX)
    ) u_min (
        .clock      (clock),
        .reset      (reset),
        .i_en       (w_sec_carry),
        .i_load     (w_setup_ok),
        .i_load_val (w_setup_time.min),
        .o_count    (w_time.min),
        .o_carry_c  (w_min_carry)
    );

    rt_mod_counter #(
        .WIDTH (8),
        .MAX   (HOUR_MAX)
    ) u_hour (
        .clock      (clock),
        .reset      (reset),
        .i_en       (w_min_carry),
        .i_load     (w_setup_ok),
        .i_load_val (w_setup_time.hour),
        .o_count    (w_time.hour),
        .o_carry_c  (w_hour_carry)
    );

    // Alarm matches hh:mm:00, so only a seconds wrap can trigger it.
    assign w_min_nxt  = w_min_carry  ? 8'd0 : w_time.min + 8'd1;
    assign w_hour_nxt = w_hour_carry ? 8'd0 :
                        (w_min_carry ? w_time.hour + 8'd1 : w_time.hour);
    assign w_trigger  = alarm_en && w_sec_carry &&
                        (w_min_nxt == r_alarm_min) && (w_hour_nxt == r_alarm_hour);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_alarm_hour <= '0;
            r_alarm_min  <= '0;
        end else if (alarm_set_imp && w_alarm_ok) begin
            r_alarm_hour <= alarm_data[15:8];
            r_alarm_min  <= alarm_data[7:0];
        end
    end

    assign w_ring_nxt = r_ring_cnt + RING_W'(1);

    // Trigger beats ack/disable; expiry counts time increments while ringing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_alarm_active <= 1'b0;
            r_ring_cnt     <= '0;
        end else if (w_trigger) begin
            r_alarm_active <= 1'b1;
            r_ring_cnt     <= '0;
        end else if (!alarm_en || alarm_ack) begin
            r_alarm_active <= 1'b0;
        end else if (r_alarm_active && w_inc) begin
            r_ring_cnt <= w_ring_nxt;
            if (w_ring_nxt == RING_LAST) begin
                r_alarm_active <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sec_imp   <= 1'b0;
            r_day_imp   <= 1'b0;
            r_setup_err <= 1'b0;
        end else begin
            r_sec_imp   <= w_inc;
            r_day_imp   <= w_hour_carry;
            r_setup_err <= w_setup_bad || w_alarm_bad;
        end
    end

    assign sec_imp      = r_sec_imp;
    assign day_imp      = r_day_imp;
    assign setup_err    = r_setup_err;
    assign alarm_active = r_alarm_active;

    // Display format is a pure view of the registered 24 h time.
    assign pm      = (w_time.hour >= 8'd12);
    assign data_ch = {(mode_12h ? rt_to_12h(w_time.hour) : w_time.hour),
                      w_time.min, w_time.sec};

endmodule
